// File: rtl/tiger_icache.sv
// Direct-mapped instruction cache between the PC logic and the fetch/decode register.
// A hit answers one cycle after the request; a miss stalls, burst-refills the line, then replays.
module tiger_icache #(
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fetch_req,
    input  logic        invalidate,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        stall_req,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [4:0]  mem_burstcount,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        LOOKUP,
        ISSUE,
        FILL,
        REPLAY
    } state_t;

    state_t state;

    logic [31:0]      data_ram [LINES*LINE_WORDS];
    logic [TAG_W-1:0] tag_ram  [LINES];
    logic [LINES-1:0] valid;

    logic [31:0]      data_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      pc_q;
    logic             req_pending;
    logic [OFF_W-1:0] beat_cnt;
    logic             inv_pending;
    logic [31:0]      instr_hold;

    logic [TAG_W-1:0] pc_q_tag;
    logic [IDX_W-1:0] pc_q_idx;
    logic [31:0]      rd_addr;
    logic [IDX_W-1:0] rd_idx;
    logic [OFF_W-1:0] rd_off;
    logic             lookup_active;
    logic             hit;
    logic             miss;
    logic             rd_en;
    logic             beat_we;
    logic             last_beat;
    logic             unused_pc_bits;

    assign pc_q_tag = pc_q[31 -: TAG_W];
    assign pc_q_idx = pc_q[OFF_W+2 +: IDX_W];

    // The replay re-reads at the held PC; otherwise the RAMs follow the live PC.
    assign rd_addr = (state == REPLAY) ? pc_q : pc;
    assign rd_idx  = rd_addr[OFF_W+2 +: IDX_W];
    assign rd_off  = rd_addr[2 +: OFF_W];

    assign lookup_active = (state == LOOKUP) && req_pending;
    assign hit           = lookup_active && valid[pc_q_idx] && (tag_q == pc_q_tag);
    assign miss          = lookup_active && !hit;
    assign rd_en         = ((state == LOOKUP) && fetch_req && !miss) || (state == REPLAY);
    assign beat_we       = (state == FILL) && mem_readdatavalid;
    assign last_beat     = beat_we && (beat_cnt == OFF_W'(LINE_WORDS - 1));

    assign instr          = hit ? data_q : instr_hold;
    assign instr_valid    = hit;
    assign stall_req      = (state != LOOKUP) || miss;
    assign mem_burstcount = 5'(LINE_WORDS);

    assign unused_pc_bits = ^pc_q[1:0];

    // NOTE: RAM arrays and their read registers carry no reset; the valid vector alone
    // decides whether stored contents mean anything, so resetting them buys nothing.
    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_ram[{pc_q_idx, beat_cnt}] <= mem_readdata;
        end
        if (last_beat) begin
            tag_ram[pc_q_idx] <= pc_q_tag;
        end
        if (rd_en) begin
            data_q <= data_ram[{rd_idx, rd_off}];
            tag_q  <= tag_ram[rd_idx];
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOOKUP;
            req_pending <= 1'b0;
            pc_q        <= '0;
            beat_cnt    <= '0;
            inv_pending <= 1'b0;
            valid       <= '0;
            instr_hold  <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
        end else begin
            req_pending <= rd_en;
            if (rd_en) begin
                pc_q <= rd_addr;
            end
            if (hit) begin
                instr_hold <= data_q;
            end

            // Invalidate outranks the final-beat valid set when both land on one edge.
            if (invalidate) begin
                valid <= '0;
            end else if (last_beat && !inv_pending) begin
                valid[pc_q_idx] <= 1'b1;
            end

            case (state)
                LOOKUP: begin
                    if (miss) begin
                        state       <= ISSUE;
                        mem_read    <= 1'b1;
                        mem_address <= {pc_q_tag, pc_q_idx, {(OFF_W+2){1'b0}}};
                    end
                end
                ISSUE: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        beat_cnt <= '0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (beat_we) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (last_beat) begin
                        inv_pending <= 1'b0;
                        state       <= REPLAY;
                    end else if (invalidate) begin
                        inv_pending <= 1'b1;
                    end
                end
                REPLAY: begin
                    state <= LOOKUP;
                end
                default: begin
                    state <= LOOKUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tiger_icache.sv
// Directed self-checking bench for tiger_icache: hits, misses, waitrequest, eviction,
// invalidate during refill and reset in the middle of a burst.
module tb_tiger_icache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_req;
    logic        invalidate;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall_req;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [4:0]  mem_burstcount;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;

    int tests = 0;
    int fails = 0;

    int          wait_left = 0;
    int          beats_left = 0;
    int          next_beat = 0;
    int          cur_beat = -1;
    int          accepts = 0;
    logic [31:0] burst_addr = '0;

    tiger_icache #(.LINE_WORDS(4), .LINES(64)) dut (
        .clk               (clk),
        .reset             (reset),
        .pc                (pc),
        .fetch_req         (fetch_req),
        .invalidate        (invalidate),
        .instr             (instr),
        .instr_valid       (instr_valid),
        .stall_req         (stall_req),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_burstcount    (mem_burstcount),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    always #5 clk = ~clk;

    // Memory contents: line 0x100 holds 0xA0..0xA3, every other word is addr ^ 0xC0DE0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000010) begin
            return 32'h0000_00A0 + 32'(a[3:2]);
        end
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory responder: accepts a burst when mem_read is high with waitrequest low,
    // then returns four beats on consecutive cycles regardless of the cache's state.
    initial begin
        logic acc;
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        forever begin
            @(negedge clk);
            acc = (mem_read === 1'b1) && (mem_waitrequest === 1'b0) && (reset === 1'b0);
            if (acc) begin
                burst_addr = mem_address;
                accepts++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                beats_left = 4;
                next_beat  = 0;
            end
            if (beats_left > 0) begin
                cur_beat          = next_beat;
                mem_readdatavalid = 1'b1;
                mem_readdata      = mem_word(burst_addr + 32'(cur_beat * 4));
                next_beat++;
                beats_left--;
            end else begin
                cur_beat          = -1;
                mem_readdatavalid = 1'b0;
            end
            if (mem_read === 1'b1 && wait_left > 0) begin
                mem_waitrequest = 1'b1;
                wait_left--;
            end else begin
                mem_waitrequest = 1'b0;
            end
        end
    end

    // The pipeline contract: pc must not move in the cycle after a stall.
    initial begin
        logic        stall_d = 1'b0;
        logic [31:0] pc_d = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && stall_d) begin
                tests++;
                if (pc !== pc_d) begin
                    fails++;
                    $display("FAIL pc_hold: pc=%h while stalled, required %h", pc, pc_d);
                end
            end
            stall_d = (stall_req === 1'b1);
            pc_d    = pc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request, then waits (bounded) for instr_valid, reporting the latency
    // in cycles after the request cycle plus what the memory port did meanwhile.
    task automatic request_and_wait(input logic [31:0] a, output int lat, output int stalls,
                                    output int rd_cycles, output logic [31:0] rd_addr,
                                    output bit addr_stable);
        pc        = a;
        fetch_req = 1'b1;
        @(posedge clk);
        #1;
        fetch_req   = 1'b0;
        lat         = 0;
        stalls      = 0;
        rd_cycles   = 0;
        rd_addr     = '0;
        addr_stable = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (stall_req === 1'b1) stalls++;
            if (mem_read === 1'b1) begin
                if (rd_cycles == 0) rd_addr = mem_address;
                else if (mem_address !== rd_addr) addr_stable = 1'b0;
                rd_cycles++;
            end
            if (instr_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
        tests++; if (mem_address !== 32'h0) begin fails++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
        tests++; if (mem_burstcount !== 5'd4) begin fails++; $display("FAIL burstcount: got %0d want 4", mem_burstcount); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cold_miss();
        int lat, st, rc;
        logic [31:0] ra;
        bit stab;
        request_and_wait(32'h100, lat, st, rc, ra, stab);
        tests++; if (ra !== 32'h100) begin fails++; $display("FAIL cold_addr: got %h want 100", ra); end
        tests++; if (rc !== 1) begin fails++; $display("FAIL cold_read_cycles: got %0d want 1", rc); end
        tests++; if (lat !== 8) begin fails++; $display("FAIL cold_latency: got %0d want 8", lat); end
        tests++; if (st !== 7) begin fails++; $display("FAIL cold_stall_cycles: got %0d want 7", st); end
        tests++; if (instr !== 32'hA0) begin fails++; $display("FAIL cold_instr: got %h want a0", instr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hit_streaming();
        logic [31:0] spc [3] = '{32'h104, 32'h108, 32'h10C};
        logic [31:0] exp [3] = '{32'hA1, 32'hA2, 32'hA3};
        bit mr_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                pc        = spc[i];
                fetch_req = 1'b1;
            end else begin
                fetch_req = 1'b0;
            end
            @(negedge clk);
            if (mem_read === 1'b1) mr_seen = 1'b1;
            if (i > 0) begin
                tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b want 1", i - 1, instr_valid); end
                tests++; if (instr !== exp[i-1]) begin fails++; $display("FAIL stream_instr[%0d]: got %h want %h", i - 1, instr, exp[i-1]); end
                tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL stream_stall[%0d]: got %b want 0", i - 1, stall_req); end
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", instr_valid); end
        tests++; if (instr !== 32'hA3) begin fails++; $display("FAIL idle_instr_hold: got %h want a3", instr); end
        tests++; if (mr_seen) begin fails++; $display("FAIL stream_mem_read: got 1 want 0"); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_waitrequest();
        int lat, st, rc;
        logic [31:0] ra;
        bit stab;
        wait_left = 3;
        request_and_wait(32'h2008, lat, st, rc, ra, stab);
        tests++; if (rc !== 4) begin fails++; $display("FAIL wait_read_cycles: got %0d want 4", rc); end
        tests++; if (ra !== 32'h2000) begin fails++; $display("FAIL wait_addr: got %h want 2000", ra); end
        tests++; if (!stab) begin fails++; $display("FAIL wait_addr_stable: got changing want stable"); end
        tests++; if (lat !== 11) begin fails++; $display("FAIL wait_latency: got %0d want 11", lat); end
        tests++; if (instr !== 32'hC0DE2008) begin fails++; $display("FAIL wait_instr: got %h want c0de2008", instr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_conflict();
        int lat, st, rc;
        logic [31:0] ra;
        bit stab;
        request_and_wait(32'h504, lat, st, rc, ra, stab);
        tests++; if (ra !== 32'h500) begin fails++; $display("FAIL evict_addr: got %h want 500", ra); end
        tests++; if (lat !== 8) begin fails++; $display("FAIL evict_latency: got %0d want 8", lat); end
        tests++; if (instr !== 32'hC0DE0504) begin fails++; $display("FAIL evict_instr: got %h want c0de0504", instr); end
        @(posedge clk);
        #1;
        request_and_wait(32'h100, lat, st, rc, ra, stab);
        tests++; if (rc !== 1 || ra !== 32'h100) begin fails++; $display("FAIL reload_addr: got %h x%0d want 100 x1", ra, rc); end
        tests++; if (lat !== 8) begin fails++; $display("FAIL reload_latency: got %0d want 8", lat); end
        tests++; if (instr !== 32'hA0) begin fails++; $display("FAIL reload_instr: got %h want a0", instr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_invalidate_fill(input logic [31:0] a, input int beat, input logic [31:0] line,
                                        input logic [31:0] exp_word);
        int lat, st, rc, acc0;
        logic [31:0] ra;
        bit stab;
        bit found = 1'b0;
        acc0 = accepts;
        fork
            request_and_wait(a, lat, st, rc, ra, stab);
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk);
                    #2;
                    if (mem_readdatavalid === 1'b1 && cur_beat == beat) begin
                        found      = 1'b1;
                        invalidate = 1'b1;
                        @(posedge clk);
                        #1;
                        invalidate = 1'b0;
                        break;
                    end
                end
            end
        join
        tests++; if (!found) begin fails++; $display("FAIL inv_beat_seen[%0d]: got none want beat", beat); end
        tests++; if (accepts - acc0 !== 2) begin fails++; $display("FAIL inv_bursts[%0d]: got %0d want 2", beat, accepts - acc0); end
        tests++; if (ra !== line) begin fails++; $display("FAIL inv_addr[%0d]: got %h want %h", beat, ra, line); end
        tests++; if (lat !== 15) begin fails++; $display("FAIL inv_latency[%0d]: got %0d want 15", beat, lat); end
        tests++; if (instr !== exp_word) begin fails++; $display("FAIL inv_instr[%0d]: got %h want %h", beat, instr, exp_word); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_invalidate_clears_all();
        int lat, st, rc;
        logic [31:0] ra;
        bit stab;
        request_and_wait(32'h308, lat, st, rc, ra, stab);
        tests++; if (lat !== 8) begin fails++; $display("FAIL inv_cleared_latency: got %0d want 8", lat); end
        tests++; if (instr !== 32'hC0DE0308) begin fails++; $display("FAIL inv_cleared_instr: got %h want c0de0308", instr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_fill();
        int lat, st, rc;
        logic [31:0] ra;
        bit stab;
        bit found = 1'b0;
        pc        = 32'h404;
        fetch_req = 1'b1;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #2;
            if (mem_readdatavalid === 1'b1 && cur_beat == 1) begin
                found = 1'b1;
                break;
            end
        end
        tests++; if (!found) begin fails++; $display("FAIL rst_beat_seen: got none want beat 1"); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL rst_mem_read: got %b want 0", mem_read); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b want 0", stall_req); end
        tests++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h want 0", instr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
        repeat (3) @(posedge clk);
        #1;
        request_and_wait(32'h404, lat, st, rc, ra, stab);
        tests++; if (ra !== 32'h400) begin fails++; $display("FAIL rst_refill_addr: got %h want 400", ra); end
        tests++; if (lat !== 8) begin fails++; $display("FAIL rst_refill_latency: got %0d want 8", lat); end
        tests++; if (instr !== 32'hC0DE0404) begin fails++; $display("FAIL rst_refill_instr: got %h want c0de0404", instr); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        pc         = '0;
        fetch_req  = 1'b0;
        invalidate = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset();
        test_cold_miss();
        test_hit_streaming();
        test_waitrequest();
        test_conflict();
        test_invalidate_fill(32'h308, 2, 32'h300, 32'hC0DE0308);
        test_invalidate_fill(32'h604, 3, 32'h600, 32'hC0DE0604);
        test_invalidate_clears_all();
        test_reset_mid_fill();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
